// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter over N_IN requesters feeding a one-entry registered output stage.
// Optional accepted-transfer counter enabled by defining RR_MUX_GRANT_CNT_EN.
module rr_mux_arbiter #(
  parameter int N_IN  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16,
  localparam int SRC_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in_valid,
  input  logic [N_IN*W-1:0] in_data,
  output logic [N_IN-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SRC_W-1:0]  out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  grant_cnt
);

  logic [SRC_W-1:0] r_ptr;
  logic             r_vld_p1;
  logic [W-1:0]     r_data_p1;
  logic [SRC_W-1:0] r_src_p1;

  logic             w_load_en;
  logic             w_found;
  logic [SRC_W-1:0] w_grant;
  logic [SRC_W:0]   w_idx;
  logic [N_IN-1:0]  w_in_ready;
  logic             w_accept;
  logic [W-1:0]     w_mux_data;
  logic [SRC_W-1:0] w_ptr_next;

  function automatic logic [W-1:0] mux_sel(input logic [N_IN*W-1:0] d,
                                           input logic [SRC_W-1:0]  s);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (s == SRC_W'(i)) res = d[i*W +: W];
    end
    return res;
  endfunction

  assign w_load_en = !r_vld_p1 || out_ready;

  // Scan from the pointer with explicit modulo wrap so non-power-of-2 N_IN works.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < N_IN; k++) begin
      w_idx = {1'b0, r_ptr} + (SRC_W+1)'(k);
      if (w_idx >= (SRC_W+1)'(N_IN)) w_idx = w_idx - (SRC_W+1)'(N_IN);
      if (!w_found && in_valid[w_idx[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_idx[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    w_in_ready = '0;
    if (rst && w_load_en && w_found) w_in_ready[w_grant] = 1'b1;
  end

  assign w_accept   = |(w_in_ready & in_valid);
  assign w_mux_data = mux_sel(in_data, w_grant);
  assign w_ptr_next = (w_grant == SRC_W'(N_IN - 1)) ? '0 : w_grant + SRC_W'(1);

  // Stage p1: registered winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_src_p1  <= '0;
      r_ptr     <= '0;
    end else if (w_load_en) begin
      if (w_accept) begin
        r_vld_p1  <= 1'b1;
        r_data_p1 <= w_mux_data;
        r_src_p1  <= w_grant;
        r_ptr     <= w_ptr_next;
      end else begin
        r_vld_p1  <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_GRANT_CNT_EN
  logic [CNT_W-1:0] r_grant_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant_cnt <= '0;
    end else if (w_accept) begin
      r_grant_cnt <= r_grant_cnt + CNT_W'(1);
    end
  end

  assign grant_cnt = r_grant_cnt;
`else
  assign grant_cnt = '0;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_vld_p1;
  assign out_data  = r_data_p1;
  assign out_src   = r_src_p1;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: table vectors, corner sequences and random traffic vs. a reference model.
module tb_rr_mux_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;
  logic [CW-1:0]  grant_cnt;

  logic [2:0]     v3;
  logic [23:0]    d3;
  logic [2:0]     r3;
  logic           ov3;
  logic [7:0]     od3;
  logic [1:0]     os3;
  logic           ordy3;
  logic [15:0]    gc3;

  rr_mux_arbiter #(.N_IN(N), .W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
    .grant_cnt(grant_cnt));

  rr_mux_arbiter #(.N_IN(3), .W(8), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_src(os3), .out_ready(ordy3),
    .grant_cnt(gc3));

  int       n_vec = 0;
  int       n_err = 0;
  int       m_ptr, m_src, m_cnt;
  bit       m_vld;
  logic [7:0] m_data;

  typedef struct {
    logic [3:0] v;
    logic       ordy;
    logic       exp_vld;
    logic [1:0] exp_src;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_src = 0; m_cnt = 0; m_vld = 0; m_data = 8'h00;
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy);
    int gi, idx;
    bit load;
    logic [3:0] er;
    logic [31:0] ecnt;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    load = !m_vld || ordy;
    gi = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (gi < 0 && v[idx]) gi = idx;
      end
    end
    er = (gi >= 0) ? 4'(1 << gi) : 4'd0;
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    @(posedge clk);
    #1;
    if (load) begin
      if (gi >= 0) begin
        m_vld = 1; m_data = d[gi*W +: W]; m_src = gi; m_ptr = (gi + 1) % N; m_cnt++;
      end else begin
        m_vld = 0;
      end
    end
`ifdef RR_MUX_GRANT_CNT_EN
    ecnt = 32'(m_cnt % 16);
`else
    ecnt = 32'd0;
`endif
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_vld});
    chk("out_data", {24'd0, out_data}, {24'd0, m_data});
    chk("out_src", {30'd0, out_src}, 32'(m_src));
    chk("grant_cnt", {28'd0, grant_cnt}, ecnt);
  endtask

  initial begin
    logic [1:0] exp3[5];
    logic [31:0] ecnt17;
    exp3[0] = 0; exp3[1] = 1; exp3[2] = 2; exp3[3] = 0; exp3[4] = 1;

    tbl[0] = '{4'hF, 1'b1, 1'b1, 2'd0};
    tbl[1] = '{4'hF, 1'b1, 1'b1, 2'd1};
    tbl[2] = '{4'hF, 1'b1, 1'b1, 2'd2};
    tbl[3] = '{4'hF, 1'b1, 1'b1, 2'd3};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 2'd0};
    tbl[5] = '{4'h4, 1'b1, 1'b1, 2'd2};
    tbl[6] = '{4'h4, 1'b1, 1'b1, 2'd2};
    tbl[7] = '{4'h4, 1'b1, 1'b1, 2'd2};
    tbl[8] = '{4'h0, 1'b1, 1'b0, 2'd2};

    rst = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    v3 = '0; d3 = '0; ordy3 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_src", {30'd0, out_src}, 32'd0);
    chk("rst_grant_cnt", {28'd0, grant_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // N_IN=3 wrap sequence
    @(negedge clk);
    v3 = 3'b111; d3 = 24'h32_31_30; ordy3 = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      chk("n3_out_valid", {31'd0, ov3}, 32'd1);
      chk("n3_out_src", {30'd0, os3}, {30'd0, exp3[j]});
      chk("n3_out_data", {24'd0, od3}, 32'h30 + {30'd0, exp3[j]});
    end
    @(negedge clk);
    v3 = '0;

    for (int t = 0; t < 9; t++) begin
      step(tbl[t].v, 32'h13_12_11_10, tbl[t].ordy);
      chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[t].exp_vld});
      chk("tbl_out_src", {30'd0, out_src}, {30'd0, tbl[t].exp_src});
    end

    // Hold FULL with 0xA5 while the sink stalls
    step(4'hF, 32'hA5A5_A5A5, 1'b1);
    for (int t = 0; t < 5; t++) begin
      step(4'hF, $urandom, 1'b0);
      chk("stall_data", {24'd0, out_data}, 32'hA5);
    end
    step(4'hF, 32'h44_33_22_11, 1'b1);

    // Asynchronous reset between edges
    step(4'hF, 32'h13_12_11_10, 1'b1);
    step(4'hF, 32'h13_12_11_10, 1'b1);
    @(negedge clk);
    in_valid = 4'hF; out_ready = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {28'd0, in_ready}, 32'd0);
    chk("arst_out_src", {30'd0, out_src}, 32'd0);
    chk("arst_grant_cnt", {28'd0, grant_cnt}, 32'd0);
    in_valid = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(4'hF, 32'h13_12_11_10, 1'b1);
    chk("post_rst_src", {30'd0, out_src}, 32'd0);

    // 17 accepted transfers since reset
    for (int t = 0; t < 16; t++) step(4'hF, $urandom, 1'b1);
`ifdef RR_MUX_GRANT_CNT_EN
    ecnt17 = 32'd1;
`else
    ecnt17 = 32'd0;
`endif
    chk("cnt17", {28'd0, grant_cnt}, ecnt17);

    for (int t = 0; t < 400; t++) begin
      step(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
